// File: rtl/ctrl_issue_unit_pkg.sv
// Shared decode-stage definitions: control enums, opcode/funct7 constants,
// the packed control bundle and the issue FSM state type.
package defines;

    typedef enum logic [2:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_RTYPE,
        ALUOP_ITYPE,
        ALUOP_BRANCH,
        ALUOP_LUI,
        ALUOP_MULDIV
    } alu_op_e;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM,
        WB_PC4,
        WB_MULDIV
    } wb_sel_e;

    typedef enum logic [2:0] {
        IMM_TYPE_R,
        IMM_TYPE_I,
        IMM_TYPE_S,
        IMM_TYPE_B,
        IMM_TYPE_U,
        IMM_TYPE_J
    } imm_sel_e;

    typedef enum logic {
        IDLE,
        MD_BUSY
    } issue_state_e;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef struct packed {
        logic     regWrite;
        logic     memRead;
        logic     memWrite;
        logic     branch;
        logic     jump;
        logic     aluSrc1;
        logic     aluSrc2;
        wb_sel_e  wbSel;
        alu_op_e  aluOp;
        imm_sel_e immSel;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_DEFAULT = '{
        regWrite: 1'b0,
        memRead:  1'b0,
        memWrite: 1'b0,
        branch:   1'b0,
        jump:     1'b0,
        aluSrc1:  1'b0,
        aluSrc2:  1'b0,
        wbSel:    WB_NONE,
        aluOp:    ALUOP_NONE,
        immSel:   IMM_TYPE_R
    };

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: produces the control bundle, flags
// RV32M ops and illegal encodings. Illegal encodings leave the bundle at default.
module ctrl_decode
    import defines::*;
#(
    parameter bit ENABLE_M = 1'b1
) (
    input  logic [31:0]  instr_i,
    output ctrl_bundle_t ctrl_o,
    output logic         is_md_o,
    output logic         illegal_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unusedBits;

    assign opcode     = instr_i[6:0];
    assign funct3     = instr_i[14:12];
    assign funct7     = instr_i[31:25];
    assign unusedBits = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        ctrl_o    = CTRL_DEFAULT;
        is_md_o   = 1'b0;
        illegal_o = 1'b0;
        case (opcode)
            OPCODE_RTYPE: begin
                if (funct7 == FUNCT7_BASE || funct7 == FUNCT7_ALT) begin
                    ctrl_o.regWrite = 1'b1;
                    ctrl_o.aluOp    = ALUOP_RTYPE;
                    ctrl_o.wbSel    = WB_ALU;
                end else if (ENABLE_M && funct7 == FUNCT7_MULDIV) begin
                    is_md_o         = 1'b1;
                    ctrl_o.regWrite = 1'b1;
                    ctrl_o.aluOp    = ALUOP_MULDIV;
                    ctrl_o.wbSel    = WB_MULDIV;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPCODE_ITYPE: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc2  = 1'b1;
                ctrl_o.aluOp    = ALUOP_ITYPE;
                ctrl_o.immSel   = IMM_TYPE_I;
                ctrl_o.wbSel    = WB_ALU;
            end
            OPCODE_LOAD: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.memRead  = 1'b1;
                ctrl_o.aluSrc2  = 1'b1;
                ctrl_o.aluOp    = ALUOP_ADD;
                ctrl_o.immSel   = IMM_TYPE_I;
                ctrl_o.wbSel    = WB_MEM;
            end
            OPCODE_STORE: begin
                ctrl_o.memWrite = 1'b1;
                ctrl_o.aluSrc2  = 1'b1;
                ctrl_o.aluOp    = ALUOP_ADD;
                ctrl_o.immSel   = IMM_TYPE_S;
            end
            OPCODE_BRANCH: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluOp  = ALUOP_BRANCH;
                ctrl_o.immSel = IMM_TYPE_B;
            end
            OPCODE_LUI: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc2  = 1'b1;
                ctrl_o.aluOp    = ALUOP_LUI;
                ctrl_o.immSel   = IMM_TYPE_U;
                ctrl_o.wbSel    = WB_ALU;
            end
            OPCODE_AUIPC: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.aluSrc1  = 1'b1;
                ctrl_o.aluSrc2  = 1'b1;
                ctrl_o.aluOp    = ALUOP_ADD;
                ctrl_o.immSel   = IMM_TYPE_U;
                ctrl_o.wbSel    = WB_ALU;
            end
            OPCODE_JAL: begin
                ctrl_o.regWrite = 1'b1;
                ctrl_o.jump     = 1'b1;
                ctrl_o.immSel   = IMM_TYPE_J;
                ctrl_o.wbSel    = WB_PC4;
            end
            OPCODE_JALR: begin
                if (funct3 == 3'b000) begin
                    ctrl_o.regWrite = 1'b1;
                    ctrl_o.jump     = 1'b1;
                    ctrl_o.aluSrc2  = 1'b1;
                    ctrl_o.aluOp    = ALUOP_ADD;
                    ctrl_o.immSel   = IMM_TYPE_I;
                    ctrl_o.wbSel    = WB_PC4;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ctrl_issue_unit.sv
// Decode-stage control/issue unit: registers the decoded control bundle into
// ID/EX and sequences multi-cycle MUL/DIV occupancy with a front-end stall.
module ctrl_issue_unit
    import defines::*;
#(
    parameter int MUL_LAT  = 2,
    parameter int DIV_LAT  = 33,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        RegWrite_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        Branch_o,
    output logic        Jump_o,
    output logic        ALUSrc1_o,
    output logic        ALUSrc2_o,
    output wb_sel_e     WBSel_o,
    output alu_op_e     ALUOp_o,
    output imm_sel_e    ImmSel_o,
    output logic        valid_o,
    output logic        illegal_o,
    output logic        md_start_o,
    output logic        md_is_div_o,
    output logic [2:0]  md_op_o,
    output logic        stall_req_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

    // Counter preload is latency-2: the accept cycle and the final busy cycle
    // are not counted, so cnt==0 marks the last cycle spent in MD_BUSY.
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = (DIV_LAT > 1) ? CNT_W'(DIV_LAT - 2) : '0;

    ctrl_bundle_t decCtrl;
    logic         decIsMd;
    logic         decIllegal;
    logic         accept;
    logic         isDiv;

    ctrl_bundle_t bundle_q,   bundle_d;
    logic         valid_q,    valid_d;
    logic         illegal_q,  illegal_d;
    logic         mdStart_q,  mdStart_d;
    logic         mdIsDiv_q,  mdIsDiv_d;
    logic [2:0]   mdOp_q,     mdOp_d;
    issue_state_e state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;

    ctrl_decode #(
        .ENABLE_M (ENABLE_M)
    ) u_decode (
        .instr_i   (instr_i),
        .ctrl_o    (decCtrl),
        .is_md_o   (decIsMd),
        .illegal_o (decIllegal)
    );

    assign accept = valid_i & ~stall_i & ~flush_i & (state_q == IDLE);
    assign isDiv  = instr_i[14];

    always_comb begin
        bundle_d  = bundle_q;
        valid_d   = valid_q;
        illegal_d = illegal_q;
        mdStart_d = mdStart_q;
        mdIsDiv_d = mdIsDiv_q;
        mdOp_d    = mdOp_q;
        state_d   = state_q;
        cnt_d     = cnt_q;

        if (flush_i || !stall_i) begin
            bundle_d  = CTRL_DEFAULT;
            valid_d   = 1'b0;
            illegal_d = 1'b0;
            mdStart_d = 1'b0;
            mdIsDiv_d = 1'b0;
            mdOp_d    = 3'b000;
        end

        if (flush_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!stall_i) begin
            if (state_q == MD_BUSY) begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (accept) begin
                bundle_d  = decCtrl;
                valid_d   = 1'b1;
                illegal_d = decIllegal;
                if (decIsMd) begin
                    mdStart_d = 1'b1;
                    mdIsDiv_d = isDiv;
                    mdOp_d    = instr_i[14:12];
                    cnt_d     = isDiv ? DIV_CNT_INIT : MUL_CNT_INIT;
                    if (isDiv ? (DIV_LAT > 1) : (MUL_LAT > 1)) begin
                        state_d = MD_BUSY;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bundle_q  <= CTRL_DEFAULT;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            mdStart_q <= 1'b0;
            mdIsDiv_q <= 1'b0;
            mdOp_q    <= 3'b000;
            state_q   <= IDLE;
            cnt_q     <= '0;
        end else begin
            bundle_q  <= bundle_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
            mdStart_q <= mdStart_d;
            mdIsDiv_q <= mdIsDiv_d;
            mdOp_q    <= mdOp_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
        end
    end

    assign RegWrite_o  = bundle_q.regWrite;
    assign MemRead_o   = bundle_q.memRead;
    assign MemWrite_o  = bundle_q.memWrite;
    assign Branch_o    = bundle_q.branch;
    assign Jump_o      = bundle_q.jump;
    assign ALUSrc1_o   = bundle_q.aluSrc1;
    assign ALUSrc2_o   = bundle_q.aluSrc2;
    assign WBSel_o     = bundle_q.wbSel;
    assign ALUOp_o     = bundle_q.aluOp;
    assign ImmSel_o    = bundle_q.immSel;
    assign valid_o     = valid_q;
    assign illegal_o   = illegal_q;
    // The start pulse stays in the register across a hold but is only shown
    // once the downstream is free to see it.
    assign md_start_o  = mdStart_q & ~stall_i;
    assign md_is_div_o = mdIsDiv_q;
    assign md_op_o     = mdOp_q;
    assign stall_req_o = (state_q == MD_BUSY);

endmodule

// File: tb/tb_ctrl_issue_unit.sv
// Self-checking bench for ctrl_issue_unit: directed cases plus randomized
// traffic compared every cycle against a transaction-level model.
module tb_ctrl_issue_unit;
    import defines::*;

    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 33;

    localparam logic [31:0] I_ADD  = 32'h003100B3;
    localparam logic [31:0] I_MUL  = 32'h023100B3;
    localparam logic [31:0] I_DIV  = 32'h023140B3;
    localparam logic [31:0] I_JAL  = 32'h0080006F;
    localparam logic [31:0] I_BADOP   = 32'h0000007F;
    localparam logic [31:0] I_BADJALR = 32'h000010E7;
    localparam logic [31:0] I_BADF7   = 32'h043100B3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] instr_i;
    logic        valid_i, stall_i, flush_i;

    logic RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, ALUSrc1_o, ALUSrc2_o;
    wb_sel_e  WBSel_o;
    alu_op_e  ALUOp_o;
    imm_sel_e ImmSel_o;
    logic valid_o, illegal_o, md_start_o, md_is_div_o, stall_req_o;
    logic [2:0] md_op_o;

    logic m0RegWrite, m0MemRead, m0MemWrite, m0Branch, m0Jump, m0Src1, m0Src2;
    wb_sel_e  m0WBSel;
    alu_op_e  m0ALUOp;
    imm_sel_e m0ImmSel;
    logic m0Valid, m0Illegal, m0Start, m0IsDiv, m0StallReq;
    logic [2:0] m0Op;

    int errors = 0;
    int checks = 0;

    logic [15:0] mCtrl;
    logic        mValid, mIllegal, mPending, mIsDiv;
    logic [2:0]  mOp;
    int          mBusyLeft;

    logic [31:0] pool [18];

    ctrl_issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ENABLE_M(1'b1)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_o(RegWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .Branch_o(Branch_o), .Jump_o(Jump_o), .ALUSrc1_o(ALUSrc1_o), .ALUSrc2_o(ALUSrc2_o),
        .WBSel_o(WBSel_o), .ALUOp_o(ALUOp_o), .ImmSel_o(ImmSel_o),
        .valid_o(valid_o), .illegal_o(illegal_o), .md_start_o(md_start_o),
        .md_is_div_o(md_is_div_o), .md_op_o(md_op_o), .stall_req_o(stall_req_o)
    );

    ctrl_issue_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .ENABLE_M(1'b0)) dutNoM (
        .clk_i(clk_i), .rst_i(rst_i), .instr_i(instr_i), .valid_i(valid_i),
        .stall_i(stall_i), .flush_i(flush_i),
        .RegWrite_o(m0RegWrite), .MemRead_o(m0MemRead), .MemWrite_o(m0MemWrite),
        .Branch_o(m0Branch), .Jump_o(m0Jump), .ALUSrc1_o(m0Src1), .ALUSrc2_o(m0Src2),
        .WBSel_o(m0WBSel), .ALUOp_o(m0ALUOp), .ImmSel_o(m0ImmSel),
        .valid_o(m0Valid), .illegal_o(m0Illegal), .md_start_o(m0Start),
        .md_is_div_o(m0IsDiv), .md_op_o(m0Op), .stall_req_o(m0StallReq)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] pk(input logic rw, mr, mw, br, jp, s1, s2,
                                       input logic [2:0] wb, alu, imm);
        return {rw, mr, mw, br, jp, s1, s2, wb, alu, imm};
    endfunction

    // Instruction-class table of the expected control bundle.
    function automatic logic [15:0] modelCtrl(input logic [31:0] ins,
                                              output logic isMd, output logic bad);
        logic [6:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        isMd = 1'b0;
        bad  = 1'b0;
        case (op)
            7'h33: begin
                if (f7 == 7'h00 || f7 == 7'h20) return pk(1,0,0,0,0,0,0, WB_ALU, ALUOP_RTYPE, IMM_TYPE_R);
                if (f7 == 7'h01) begin
                    isMd = 1'b1;
                    return pk(1,0,0,0,0,0,0, WB_MULDIV, ALUOP_MULDIV, IMM_TYPE_R);
                end
                bad = 1'b1;
                return 16'h0;
            end
            7'h13: return pk(1,0,0,0,0,0,1, WB_ALU, ALUOP_ITYPE, IMM_TYPE_I);
            7'h03: return pk(1,1,0,0,0,0,1, WB_MEM, ALUOP_ADD, IMM_TYPE_I);
            7'h23: return pk(0,0,1,0,0,0,1, WB_NONE, ALUOP_ADD, IMM_TYPE_S);
            7'h63: return pk(0,0,0,1,0,0,0, WB_NONE, ALUOP_BRANCH, IMM_TYPE_B);
            7'h37: return pk(1,0,0,0,0,0,1, WB_ALU, ALUOP_LUI, IMM_TYPE_U);
            7'h17: return pk(1,0,0,0,0,1,1, WB_ALU, ALUOP_ADD, IMM_TYPE_U);
            7'h6F: return pk(1,0,0,0,1,0,0, WB_PC4, ALUOP_NONE, IMM_TYPE_J);
            7'h67: begin
                if (f3 == 3'd0) return pk(1,0,0,0,1,0,1, WB_PC4, ALUOP_ADD, IMM_TYPE_I);
                bad = 1'b1;
                return 16'h0;
            end
            default: begin
                bad = 1'b1;
                return 16'h0;
            end
        endcase
    endfunction

    task automatic modelReset();
        mCtrl = 16'h0; mValid = 1'b0; mIllegal = 1'b0; mPending = 1'b0;
        mIsDiv = 1'b0; mOp = 3'd0; mBusyLeft = 0;
    endtask

    task automatic modelBubble();
        mCtrl = 16'h0; mValid = 1'b0; mIllegal = 1'b0; mPending = 1'b0;
        mIsDiv = 1'b0; mOp = 3'd0;
    endtask

    // Transaction view: an M-op blocks issue for (latency-1) unstalled cycles.
    task automatic modelStep(input logic [31:0] ins, input logic v, st, fl);
        logic isMd, bad;
        logic [15:0] c;
        if (fl) begin
            modelBubble();
            mBusyLeft = 0;
        end else if (!st) begin
            if (mBusyLeft > 0) begin
                modelBubble();
                mBusyLeft--;
            end else if (v) begin
                c = modelCtrl(ins, isMd, bad);
                mCtrl = c; mValid = 1'b1; mIllegal = bad;
                mPending = isMd;
                mIsDiv = isMd & ins[14];
                mOp = isMd ? ins[14:12] : 3'd0;
                mBusyLeft = isMd ? ((ins[14] ? DIV_LAT : MUL_LAT) - 1) : 0;
            end else begin
                modelBubble();
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compareAll();
        logic [23:0] act, exp;
        act = {RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, ALUSrc1_o, ALUSrc2_o,
               WBSel_o, ALUOp_o, ImmSel_o, valid_o, illegal_o, md_start_o, md_is_div_o,
               md_op_o, stall_req_o};
        exp = {mCtrl, mValid, mIllegal, mPending & ~stall_i, mIsDiv, mOp, (mBusyLeft > 0)};
        checkOutput("cycle", {8'h0, act}, {8'h0, exp});
    endtask

    // Drive one cycle of inputs, compare the current outputs, then clock.
    task automatic applyStimulus(input logic [31:0] ins, input logic v, st, fl);
        instr_i = ins; valid_i = v; stall_i = st; flush_i = fl;
        #1 compareAll();
        @(posedge clk_i);
        modelStep(ins, v, st, fl);
        #5;
    endtask

    task automatic runBusy(input int stallFrom, input int stallLen, output int busy, output int starts);
        busy = 0;
        starts = 0;
        for (int k = 0; k < 200; k++) begin
            if (md_start_o) starts++;
            if (!stall_req_o) break;
            busy++;
            applyStimulus(I_ADD, 1'b0, (k >= stallFrom && k < stallFrom + stallLen), 1'b0);
        end
    endtask

    initial begin
        int busy, starts;
        int unsigned pick;
        logic [31:0] ins;

        pool[0]  = I_ADD;        pool[1]  = 32'h403100B3; pool[2]  = 32'h00510093;
        pool[3]  = 32'h0000A083; pool[4]  = 32'h0020A023; pool[5]  = 32'h00208063;
        pool[6]  = 32'h000010B7; pool[7]  = 32'h00001097; pool[8]  = I_JAL;
        pool[9]  = 32'h000080E7; pool[10] = I_MUL;        pool[11] = I_DIV;
        pool[12] = 32'h023160B3; pool[13] = 32'h023110B3; pool[14] = 32'h023150B3;
        pool[15] = I_BADOP;      pool[16] = I_BADF7;      pool[17] = I_BADJALR;

        rst_i = 1'b1; instr_i = 32'h0; valid_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        modelReset();
        #12;
        checkOutput("rst_valid", valid_o, 0);
        checkOutput("rst_stall_req", stall_req_o, 0);
        checkOutput("rst_md_start", md_start_o, 0);
        checkOutput("rst_wbsel", WBSel_o, WB_NONE);
        checkOutput("rst_aluop", ALUOp_o, ALUOP_NONE);
        checkOutput("rst_immsel", ImmSel_o, IMM_TYPE_R);
        checkOutput("rst_regwrite", RegWrite_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;

        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("add_regwrite", RegWrite_o, 1);
        checkOutput("add_aluop", ALUOp_o, ALUOP_RTYPE);
        checkOutput("add_wbsel", WBSel_o, WB_ALU);
        checkOutput("add_valid", valid_o, 1);
        checkOutput("add_stall_req", stall_req_o, 0);

        applyStimulus(I_MUL, 1'b1, 1'b0, 1'b0);
        checkOutput("mul_start", md_start_o, 1);
        checkOutput("mul_is_div", md_is_div_o, 0);
        checkOutput("mul_stall_req", stall_req_o, 1);
        checkOutput("mul_disabled", {m0RegWrite, m0MemRead, m0MemWrite, m0Branch, m0Jump,
                    m0Src1, m0Src2, m0WBSel, m0ALUOp, m0ImmSel, m0Valid, m0Illegal,
                    m0Start, m0IsDiv, m0Op, m0StallReq}, 32'h000000C0);
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("mul_busy_reject_valid", valid_o, 0);
        checkOutput("mul_start_gone", md_start_o, 0);
        checkOutput("mul_stall_done", stall_req_o, 0);
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("mul_next_accept", valid_o, 1);

        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        checkOutput("div_is_div", md_is_div_o, 1);
        runBusy(1000, 0, busy, starts);
        checkOutput("div_busy_cycles", busy, 32);
        checkOutput("div_starts", starts, 1);

        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        runBusy(10, 5, busy, starts);
        checkOutput("div_stalled_busy", busy, 37);
        checkOutput("div_stalled_starts", starts, 1);

        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_pre_busy", stall_req_o, 1);
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b1);
        checkOutput("flush_valid", valid_o, 0);
        checkOutput("flush_stall_req", stall_req_o, 0);
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_then_accept", valid_o, 1);

        applyStimulus(I_BADOP, 1'b1, 1'b0, 1'b0);
        checkOutput("badop", {illegal_o, valid_o, RegWrite_o, MemWrite_o}, 4'b1100);
        applyStimulus(I_BADJALR, 1'b1, 1'b0, 1'b0);
        checkOutput("badjalr", {illegal_o, valid_o, RegWrite_o, MemWrite_o}, 4'b1100);
        applyStimulus(I_BADF7, 1'b1, 1'b0, 1'b0);
        checkOutput("badf7", {illegal_o, valid_o, RegWrite_o, MemWrite_o}, 4'b1100);

        applyStimulus(I_JAL, 1'b1, 1'b0, 1'b0);
        checkOutput("jal_immsel", ImmSel_o, IMM_TYPE_J);
        checkOutput("jal_jump", Jump_o, 1);
        checkOutput("jal_wbsel", WBSel_o, WB_PC4);

        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 19);
            ins  = (pick < 18) ? pool[pick] : $urandom;
            applyStimulus(ins, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 24) == 0));
        end
        applyStimulus(I_ADD, 1'b0, 1'b0, 1'b1);

        applyStimulus(I_DIV, 1'b1, 1'b0, 1'b0);
        #2 rst_i = 1'b1;
        #1;
        checkOutput("async_rst_outputs", {RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o,
                    ALUSrc1_o, ALUSrc2_o, WBSel_o, ALUOp_o, ImmSel_o, valid_o, illegal_o,
                    md_start_o, md_is_div_o, md_op_o, stall_req_o}, 32'h0);
        modelReset();
        @(negedge clk_i);
        rst_i = 1'b0;
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        applyStimulus(I_MUL, 1'b1, 1'b0, 1'b0);
        applyStimulus(I_ADD, 1'b1, 1'b0, 1'b0);
        applyStimulus(I_ADD, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
